// File: rtl/instr_fetch_pkg.sv
// Shared definitions for the instruction fetch stage: state encoding,
// NOP word, sequential PC increment and the opcode field width.
package instr_fetch_pkg;

    localparam int          INSTR_OPCODE_WIDTH = 7;
    localparam logic [31:0] NOP_INSTR          = 32'h00000013;
    localparam int          PC_INC             = 4;
    localparam int          ALIGN_MASK         = 3;

    typedef enum logic [1:0] {
        ST_START = 2'd0,
        ST_REQ   = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FAULT = 2'd3
    } fetch_state_e;

    // True when a 32-bit address is not on a word boundary.
    function automatic logic is_misaligned(input logic [1:0] low_bits);
        return low_bits != 2'b00;
    endfunction

endpackage

// File: rtl/instr_fetch_pc_reg.sv
// Fetch-PC register: synchronous reset to RESET_PC, redirect load with
// word-alignment masking, and sequential +4 increment that wraps at 2^XLEN.
module pc_reg
    import instr_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic            inc,
    input  logic [XLEN-1:0] target,
    output logic [XLEN-1:0] fetch_pc
);

    logic [XLEN-1:0] load_value;

    // Loaded targets always land on a word boundary; when the fault check
    // is enabled only aligned targets ever reach this port, so masking is
    // harmless there and mandatory otherwise.
    always_comb begin
        load_value = target & ~XLEN'(ALIGN_MASK);
    end

    // PC update: redirect has priority over the sequential increment.
    always_ff @(posedge clk) begin
        if (rst) begin
            fetch_pc <= RESET_PC;
        end else if (load) begin
            fetch_pc <= load_value;
        end else if (inc) begin
            fetch_pc <= fetch_pc + XLEN'(PC_INC);
        end
    end

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch stage: fetch-PC, request/acknowledge read of
// instruction memory, instruction register and the handoff to the main
// controller. Optional redirect-alignment fault is enabled by defining
// FETCH_MISALIGN_CHECK_EN; without it, redirect targets are word-masked.
module instr_fetch
    import instr_fetch_pkg::*;
#(
    parameter int              XLEN     = 32,
    parameter logic [XLEN-1:0] RESET_PC = '0
) (
    input  logic                          clk,
    input  logic                          rst,
    output logic                          imemReq,
    output logic [XLEN-1:0]               imemAddr,
    input  logic                          imemAck,
    input  logic [31:0]                   imemData,
    input  logic                          fetchNext,
    input  logic                          pcLoad,
    input  logic [XLEN-1:0]               pcTarget,
    output logic [XLEN-1:0]               pc,
    output logic [31:0]                   instr,
    output logic [INSTR_OPCODE_WIDTH-1:0] opCode,
    output logic                          instrValid,
    output logic                          misalignFault
);

    fetch_state_e    state;
    fetch_state_e    next_state;
    logic [XLEN-1:0] fetchPc;
    logic            pc_load;
    logic            pc_inc;
    logic            take_fault;

`ifdef FETCH_MISALIGN_CHECK_EN
    assign take_fault = (state == ST_HOLD) && pcLoad && is_misaligned(pcTarget[1:0]);
`else
    assign take_fault = 1'b0;
`endif

    // A redirect beats a sequential fetch; a faulting redirect loads nothing.
    assign pc_load = (state == ST_HOLD) && pcLoad && !take_fault;
    assign pc_inc  = (state == ST_HOLD) && !pcLoad && fetchNext;

    pc_reg #(
        .XLEN     (XLEN),
        .RESET_PC (RESET_PC)
    ) u_pc_reg (
        .clk      (clk),
        .rst      (rst),
        .load     (pc_load),
        .inc      (pc_inc),
        .target   (pcTarget),
        .fetch_pc (fetchPc)
    );

    assign imemAddr = fetchPc;
    assign opCode   = instr[INSTR_OPCODE_WIDTH-1:0];

    // State register.
    always_ff @(posedge clk) begin
        if (rst) begin
            state <= ST_START;
        end else begin
            state <= next_state;
        end
    end

    // Next-state logic; controller requests are only honoured in HOLD.
    always_comb begin
        next_state = state;
        case (state)
            ST_START: next_state = ST_REQ;
            ST_REQ:   if (imemAck) next_state = ST_HOLD;
            ST_HOLD: begin
                if (take_fault) begin
                    next_state = ST_FAULT;
                end else if (pcLoad || fetchNext) begin
                    next_state = ST_REQ;
                end
            end
            ST_FAULT: next_state = ST_FAULT;
            default:  next_state = ST_START;
        endcase
    end

    // Moore outputs decoded from the state register.
    always_comb begin
        imemReq    = (state == ST_REQ);
        instrValid = (state == ST_HOLD);
`ifdef FETCH_MISALIGN_CHECK_EN
        misalignFault = (state == ST_FAULT);
`else
        misalignFault = 1'b0;
`endif
    end

    // Instruction register and its PC; acks outside REQ are dropped.
    always_ff @(posedge clk) begin
        if (rst) begin
            instr <= NOP_INSTR;
            pc    <= RESET_PC;
        end else if ((state == ST_REQ) && imemAck) begin
            instr <= imemData;
            pc    <= fetchPc;
        end else if (take_fault) begin
            pc    <= pcTarget;
        end
    end

endmodule

// File: tb/tb_instr_fetch.sv
// Randomized self-checking bench for instr_fetch with a transaction-level
// reference model, plus directed sequences for the key fetch scenarios.
module tb_instr_fetch;

`ifdef FETCH_MISALIGN_CHECK_EN
    localparam bit CHK_EN = 1'b1;
`else
    localparam bit CHK_EN = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        imemReq;
    logic [31:0] imemAddr;
    logic        imemAck = 1'b0;
    logic [31:0] imemData = '0;
    logic        fetchNext = 1'b0;
    logic        pcLoad = 1'b0;
    logic [31:0] pcTarget = '0;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [6:0]  opCode;
    logic        instrValid;
    logic        misalignFault;

    int checks = 0;
    int errors = 0;

    instr_fetch #(.XLEN(32), .RESET_PC(32'h0)) dut (
        .clk           (clk),
        .rst           (rst),
        .imemReq       (imemReq),
        .imemAddr      (imemAddr),
        .imemAck       (imemAck),
        .imemData      (imemData),
        .fetchNext     (fetchNext),
        .pcLoad        (pcLoad),
        .pcTarget      (pcTarget),
        .pc            (pc),
        .instr         (instr),
        .opCode        (opCode),
        .instrValid    (instrValid),
        .misalignFault (misalignFault)
    );

    always #5 clk = ~clk;

    // Reference model: what the stage owes the outside world.
    bit          m_known = 0;
    bit          m_idle;     // one idle cycle owed after reset
    bit          m_req;      // a read is outstanding
    bit          m_valid;    // an instruction is held for the controller
    bit          m_fault;
    logic [31:0] m_fpc;
    logic [31:0] m_pc;
    logic [31:0] m_instr;

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic compare_model();
        if (m_known) begin
            check_val("imemReq", 32'(imemReq), 32'(m_req));
            check_val("instrValid", 32'(instrValid), 32'(m_valid));
            check_val("misalignFault", 32'(misalignFault), 32'(m_fault));
            check_val("pc", pc, m_pc);
            check_val("instr", instr, m_instr);
            check_val("opCode", 32'(opCode), 32'(m_instr[6:0]));
            if (m_req) check_val("imemAddr", imemAddr, m_fpc);
        end
    endtask

    task automatic model_step(input logic r, input logic a, input logic [31:0] d,
                              input logic f, input logic l, input logic [31:0] t);
        if (r) begin
            m_known = 1; m_idle = 1; m_req = 0; m_valid = 0; m_fault = 0;
            m_fpc = 32'h0; m_pc = 32'h0; m_instr = 32'h00000013;
        end else if (!m_known || m_fault) begin
            // nothing changes
        end else if (m_idle) begin
            m_idle = 0; m_req = 1;
        end else if (m_req) begin
            if (a) begin
                m_instr = d; m_pc = m_fpc; m_req = 0; m_valid = 1;
            end
        end else if (m_valid) begin
            if (l) begin
                m_valid = 0;
                if (CHK_EN && t[1:0] != 2'b00) begin
                    m_fault = 1; m_pc = t;
                end else begin
                    m_fpc = {t[31:2], 2'b00}; m_req = 1;
                end
            end else if (f) begin
                m_fpc = m_fpc + 32'd4; m_req = 1; m_valid = 0;
            end
        end
    endtask

    // One clock: check outputs, drive inputs, advance model, land on next negedge.
    task automatic step(input logic r, input logic a, input logic [31:0] d,
                        input logic f, input logic l, input logic [31:0] t);
        compare_model();
        rst = r; imemAck = a; imemData = d; fetchNext = f; pcLoad = l; pcTarget = t;
        model_step(r, a, d, f, l, t);
        @(posedge clk);
        @(negedge clk);
    endtask

    initial begin
        logic [31:0] tgt;
        @(negedge clk);

        // First fetch after reset with an always-acking memory.
        step(1, 0, 0, 0, 0, 0);
        step(0, 1, 32'h00500093, 0, 0, 0);
        check_val("tp1_req_c2", 32'(imemReq), 32'd1);
        check_val("tp1_addr_c2", imemAddr, 32'h0);
        step(0, 1, 32'h00500093, 0, 0, 0);
        check_val("tp1_valid_c3", 32'(instrValid), 32'd1);
        check_val("tp1_op_c3", 32'(opCode), 32'h13);
        check_val("tp1_pc_c3", pc, 32'h0);

        // Sequential fetch with three wait cycles.
        step(0, 0, 0, 1, 0, 0);
        for (int i = 0; i < 3; i++) begin
            check_val("tp2_addr_wait", imemAddr, 32'h4);
            step(0, 0, 0, 0, 0, 0);
        end
        check_val("tp2_addr_ack", imemAddr, 32'h4);
        step(0, 1, 32'h00100113, 0, 0, 0);
        check_val("tp2_pc", pc, 32'h4);
        check_val("tp2_valid", 32'(instrValid), 32'd1);
        check_val("tp2_instr", instr, 32'h00100113);

        // Redirect beats sequential fetch.
        step(0, 0, 0, 1, 1, 32'h100);
        check_val("tp3_addr", imemAddr, 32'h100);
        step(0, 1, 32'h00000033, 0, 0, 0);

        // Sequential fetch wraps past the top of the address space.
        step(0, 0, 0, 0, 1, 32'hFFFFFFFC);
        step(0, 1, 32'h00000013, 0, 0, 0);
        step(0, 0, 0, 1, 0, 0);
        check_val("tp4_wrap_addr", imemAddr, 32'h0);
        step(0, 1, 32'h0000006F, 0, 0, 0);

        // Reset during an outstanding request; the late ack is dropped.
        step(0, 0, 0, 1, 0, 0);
        check_val("tp5_req_before", 32'(imemReq), 32'd1);
        step(1, 0, 0, 0, 0, 0);
        check_val("tp5_req_after_rst", 32'(imemReq), 32'd0);
        step(0, 1, 32'hDEADBEEF, 0, 0, 0);
        check_val("tp5_instr_nop", instr, 32'h00000013);
        check_val("tp5_valid", 32'(instrValid), 32'd0);
        check_val("tp5_refetch", imemAddr, 32'h0);
        step(0, 1, 32'h00500093, 0, 0, 0);

        // Misaligned redirect.
        step(0, 0, 0, 0, 1, 32'h102);
`ifdef FETCH_MISALIGN_CHECK_EN
        check_val("tp6_fault", 32'(misalignFault), 32'd1);
        check_val("tp6_pc", pc, 32'h102);
        for (int i = 0; i < 3; i++) begin
            check_val("tp6_no_req", 32'(imemReq), 32'd0);
            step(0, 1, 0, 1, 1, 32'h200);
        end
        step(1, 0, 0, 0, 0, 0);
`else
        check_val("tp6_masked_addr", imemAddr, 32'h100);
        step(0, 1, 32'h00000013, 0, 0, 0);
`endif

        // Randomized traffic against the model.
        for (int n = 0; n < 4000; n++) begin
            case ($urandom_range(3))
                0:       tgt = 32'hFFFFFFFC;
                1:       tgt = $urandom() & 32'hFFFFFFFC;
                default: tgt = $urandom();
            endcase
            step(($urandom_range(59) == 0),
                 ($urandom_range(1) == 1),
                 $urandom(),
                 ($urandom_range(9) < 3),
                 ($urandom_range(9) < 2),
                 tgt);
        end
        compare_model();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
